// File: rtl/cpu16_pkg.sv
// Shared constants for the 16-bit MIPS-style datapath register file.
package cpu16_pkg;

    localparam int DW   = 16;
    localparam int AW   = 3;
    localparam int NREG = 8;

    localparam logic [AW-1:0] REG_ZERO = 3'd0;

endpackage : cpu16_pkg

// File: rtl/rf_read_port.sv
// One asynchronous register-file read port: 8-way register select with a
// write-first bypass so a same-cycle write-back is visible immediately.
module rf_read_port
    import cpu16_pkg::*;
(
    input  logic [NREG-1:0][DW-1:0] regs_i,
    input  logic [AW-1:0]           ra_i,
    input  logic                    we_i,
    input  logic [AW-1:0]           wa_i,
    input  logic [DW-1:0]           wd_i,
    output logic [DW-1:0]           rd_o
);

    logic bypass_hit;

    // R0 never bypasses: a write aimed at R0 is discarded by the array.
    assign bypass_hit = we_i && (wa_i == ra_i) && (ra_i != REG_ZERO);

    // Select bypass data, the hardwired zero, or the stored register.
    always_comb begin
        rd_o = '0;
        if (bypass_hit) begin
            rd_o = wd_i;
        end else if (ra_i != REG_ZERO) begin
            rd_o = regs_i[ra_i];
        end
    end

endmodule : rf_read_port

// File: rtl/regfile_8x16_sb.sv
// 8x16 register file with two bypassed async read ports, one sync write
// port and a per-register busy scoreboard that raises an operand stall.
module regfile_8x16_sb
    import cpu16_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [AW-1:0]   wa,
    input  logic [DW-1:0]   wd,
    input  logic [AW-1:0]   ra0,
    input  logic [AW-1:0]   ra1,
    input  logic            use0,
    input  logic            use1,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_rd,
    output logic [DW-1:0]   rd0,
    output logic [DW-1:0]   rd1,
    output logic [NREG-1:0] busy,
    output logic            stall
);

    // Storage is a flop array rather than block RAM because both reads
    // must be combinational.
    logic [NREG-1:0][DW-1:0] regs_q;
    logic [NREG-1:0][DW-1:0] regs_d;
    logic [NREG-1:0]         busy_q;
    logic [NREG-1:0]         busy_d;

    logic haz0;
    logic haz1;

    // R0 is hardwired: never written, never busy.
    assign regs_d[0] = '0;
    assign busy_d[0] = 1'b0;

    // Per-register write decode and scoreboard next state. A new issue to
    // the same register wins over a retiring write-back, because the
    // register now waits on the younger producer.
    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : g_reg
            logic wr_hit;
            logic iss_hit;

            assign wr_hit       = we && (wa == AW'(gi));
            assign iss_hit      = iss_en && (iss_rd == AW'(gi));
            assign regs_d[gi]   = wr_hit ? wd : regs_q[gi];
            assign busy_d[gi]   = iss_hit | (busy_q[gi] & ~wr_hit);
        end
    endgenerate

    // State update; reset clears data and discards all pending busy bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    rf_read_port u_port0 (
        .regs_i (regs_q),
        .ra_i   (ra0),
        .we_i   (we),
        .wa_i   (wa),
        .wd_i   (wd),
        .rd_o   (rd0)
    );

    rf_read_port u_port1 (
        .regs_i (regs_q),
        .ra_i   (ra1),
        .we_i   (we),
        .wa_i   (wa),
        .wd_i   (wd),
        .rd_o   (rd1)
    );

    // A busy operand is only a hazard if it is consumed and not being
    // delivered by the bypass this very cycle. busy_q[0] is always 0.
    always_comb begin
        haz0  = use0 && busy_q[ra0] && !(we && (wa == ra0));
        haz1  = use1 && busy_q[ra1] && !(we && (wa == ra1));
        stall = haz0 || haz1;
    end

    assign busy = busy_q;

endmodule : regfile_8x16_sb

// File: doc/regfile_8x16_sb.md
Name: regfile_8x16_sb

Overview:
- 8-entry x 16-bit general register file with two asynchronous read ports, one synchronous write port and a per-register busy scoreboard.
- Sits directly upstream of the operand-select muxes in the 16-bit MIPS datapath. Its read data feeds the ALU/operand 8-to-1 selection stage.
- The scoreboard flags registers with an outstanding write-back and raises a stall when a consumer reads one.

Parameters:
DW, 16, data width per register
NREG, 8, number of registers (fixed at 8; address width follows)
AW, 3, register address width, log2(NREG)

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous reset, active-high
we  input  1  write-back enable
wa  input  3  write-back register address
wd  input  16  write-back data
ra0  input  3  read port 0 address
ra1  input  3  read port 1 address
use0  input  1  read port 0 operand actually consumed this cycle
use1  input  1  read port 1 operand actually consumed this cycle
iss_en  input  1  instruction issued; marks its destination busy
iss_rd  input  3  destination register of the issued instruction
rd0  output  16  read port 0 data
rd1  output  16  read port 1 data
busy  output  8  scoreboard vector, bit i = R[i] has a pending write
stall  output  1  operand hazard, hold issue this cycle

Behaviour:
- Single clock clk; reset rst is synchronous and active-high.
- Reset: on a posedge with rst=1, all R[i]=0 and busy=0. rst overrides we and iss_en in the same cycle.
- After reset: rd0=rd1=0 for any address, stall=0.
- R0 is hardwired to zero. Reads of address 0 return 0, writes to address 0 are ignored, and busy[0] is always 0.
- Write: at posedge, if we=1 and wa!=0, then R[wa]<=wd. Write latency is 1 cycle.
- Read: combinational, 0-cycle latency, with write-first bypass.
  - If we=1 and wa==raN and raN!=0, then rdN=wd.
  - Otherwise rdN=R[raN].
  - Both ports may address the same register; each port bypasses independently.
- Scoreboard update at posedge, evaluated per bit i in 1..7:
  - set_i = iss_en & (iss_rd==i)
  - clr_i = we & (wa==i)
  - set_i=1 gives busy[i]<=1. Set wins over a simultaneous clear because a newer producer was issued.
  - set_i=0 and clr_i=1 gives busy[i]<=0.
  - Otherwise busy[i] holds.
- A write-back with busy[wa]=0 is legal: data is written and busy stays 0.
- Stall (combinational):
  - haz0 = use0 & busy[ra0] & ~(we & wa==ra0)
  - haz1 = use1 & busy[ra1] & ~(we & wa==ra1)
  - stall = haz0 | haz1
  - Same-cycle write-back resolves the hazard through the bypass, so no stall is raised.
- Issue while stalled: the block does not gate iss_en. The issuing stage must hold iss_en=0 while stall=1.
- An issue whose own sources are busy still sets busy[iss_rd] if the issue is presented. This is caller responsibility.
- Reset mid-operation: all pending busy bits are discarded. Write-backs that arrive later, after reset, land normally.
- No X propagation: every address value 0..7 is defined.

Decomposition:
- Shared package cpu16_pkg holds:
  - DW=16, AW=3, NREG=8
  - REG_ZERO=3'd0
- One sub-module, rf_read_port: a 16-bit 8-way register select plus write bypass compare. It is instantiated twice, once for rd0 and once for rd1.
- Storage, write decode and scoreboard live in the top module.

Test Plan:
1. Reset then read all addresses -> rd0=rd1=16'h0000 and busy=8'h00, stall=0. Then write R0=16'hBEEF -> R0 still reads 0.
2. Cycle 1: we=1, wa=3, wd=16'h1234 with ra0=3 -> rd0=16'h1234 in the same cycle (bypass). Cycle 2: we=0 -> rd0=16'h1234 from storage.
3. iss_en=1, iss_rd=5. Next cycle ra1=5, use1=1 -> busy=8'h20, stall=1. With use1=0 -> stall=0.
4. busy[5]=1; same cycle we=1, wa=5, wd=16'hA5A5, ra0=5, use0=1 -> stall=0, rd0=16'hA5A5. Next cycle busy[5]=0.
5. Same cycle iss_en=1, iss_rd=2 and we=1, wa=2, wd=16'h0F0F -> R2=16'h0F0F and busy[2]=1 (set wins).
6. busy=8'h6C and R4=16'h7777; assert rst=1 together with we=1, wa=4, wd=16'h1111 -> next cycle busy=0 and R4=0.
